// File: rtl/simd_add_sequencer.sv
// Beat-serial front/back end for the 256-bit SIMD add/sub unit: gathers operands, runs one add, streams the result.
// Optional per-lane zero flags are built when SIMD_SEQ_ZERO_FLAG_EN is defined.
module simd_add_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic [2:0]   cmd_mode_i,
   input  logic         cmd_sub_i,
   input  logic         cmd_imm_i,
   input  logic [7:0]   cmd_imm_val_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [31:0]  in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [31:0]  out_data_o,
   output logic         out_last_o,
   output logic [255:0] add_a_o,
   output logic [255:0] add_b_o,
   output logic [2:0]   add_mode_o,
   output logic         add_sub_o,
   output logic         add_imm_flag_o,
   output logic [7:0]   add_imm_reg_o,
   input  logic [255:0] add_result_i,
   output logic         busy_o
`ifdef SIMD_SEQ_ZERO_FLAG_EN
   ,
   output logic [31:0]  lane_zero_o
`endif
);

   localparam int SIMD_WIDTH = 256;
   localparam int BEAT_W     = 32;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [SIMD_WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]              mode_q, mode_d;
   logic                    sub_q, sub_d, imm_q, imm_d;
   logic [7:0]              immv_q, immv_d;
   logic                    cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic [BEAT_W-1:0]       out_data_q, out_data_d;

`ifdef SIMD_SEQ_ZERO_FLAG_EN
   logic [31:0]             lz_q, lz_d;

   function automatic logic [31:0] zero_flags(input logic [SIMD_WIDTH-1:0] r, input logic [2:0] m);
      logic [31:0] z;
      z = '0;
      case (m)
         3'd0: for (int i = 0; i < 32; i++) z[i] = (r[i*8 +: 8] == '0);
         3'd1: for (int i = 0; i < 16; i++) z[i] = (r[i*16 +: 16] == '0);
         3'd2: for (int i = 0; i < 8; i++)  z[i] = (r[i*32 +: 32] == '0);
         3'd3: for (int i = 0; i < 4; i++)  z[i] = (r[i*64 +: 64] == '0);
         3'd4: for (int i = 0; i < 2; i++)  z[i] = (r[i*128 +: 128] == '0);
         default: z[0] = (r == '0);
      endcase
      return z;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      mode_d  = mode_q;
      sub_d   = sub_q;
      imm_d   = imm_q;
      immv_d  = immv_q;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
      lz_d    = lz_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               mode_d  = cmd_mode_i;
               sub_d   = cmd_sub_i;
               imm_d   = cmd_imm_i;
               immv_d  = cmd_imm_val_i;
               b_d     = '0;
               cnt_d   = 3'd0;
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            if (in_valid_i) begin
               a_d[{cnt_q, 5'd0} +: BEAT_W] = in_data_i;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = imm_q ? S_EXEC : S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            if (in_valid_i) begin
               b_d[{cnt_q, 5'd0} +: BEAT_W] = in_data_i;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // Adder inputs have been stable since the last operand beat, so the sum is settled here.
            res_d   = add_result_i;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
            lz_d    = zero_flags(add_result_i, mode_q);
`endif
            cnt_d   = 3'd0;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_ready_i) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Handshake flags and the output beat are registered from the next state.
      cmd_ready_d = (state_d == S_IDLE);
      in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      out_valid_d = (state_d == S_DRAIN);
      out_last_d  = (state_d == S_DRAIN) && (cnt_d == 3'd7);
      busy_d      = (state_d != S_IDLE);
      out_data_d  = (state_d == S_DRAIN) ? res_d[{cnt_d, 5'd0} +: BEAT_W] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         mode_q      <= 3'd0;
         sub_q       <= 1'b0;
         imm_q       <= 1'b0;
         immv_q      <= 8'd0;
         cmd_ready_q <= 1'b1;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_data_q  <= '0;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
         lz_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         mode_q      <= mode_d;
         sub_q       <= sub_d;
         imm_q       <= imm_d;
         immv_q      <= immv_d;
         cmd_ready_q <= cmd_ready_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         out_data_q  <= out_data_d;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
         lz_q        <= lz_d;
`endif
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign in_ready_o     = in_ready_q;
   assign out_valid_o    = out_valid_q;
   assign out_last_o     = out_last_q;
   assign out_data_o     = out_data_q;
   assign busy_o         = busy_q;
   assign add_a_o        = a_q;
   assign add_b_o        = b_q;
   assign add_mode_o     = mode_q;
   assign add_sub_o      = sub_q;
   assign add_imm_flag_o = imm_q;
   assign add_imm_reg_o  = immv_q;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
   assign lane_zero_o    = lz_q;
`endif

endmodule

// File: tb/tb_simd_add_sequencer.sv
// Directed bench for simd_add_sequencer with a behavioural lane-wise adder standing in for the SIMD unit.
module tb_simd_add_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0, cmd_ready;
   logic [2:0]   cmd_mode = 3'd0;
   logic         cmd_sub = 1'b0, cmd_imm = 1'b0;
   logic [7:0]   cmd_imm_val = 8'd0;
   logic         in_valid = 1'b0, in_ready;
   logic [31:0]  in_data = 32'd0;
   logic         out_valid, out_ready = 1'b0, out_last;
   logic [31:0]  out_data;
   logic [255:0] add_a, add_b, add_result;
   logic [2:0]   add_mode;
   logic         add_sub, add_imm_flag, busy;
   logic [7:0]   add_imm_reg;
`ifdef SIMD_SEQ_ZERO_FLAG_EN
   logic [31:0]  lane_zero;
`endif

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   simd_add_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_mode_i(cmd_mode),
      .cmd_sub_i(cmd_sub), .cmd_imm_i(cmd_imm), .cmd_imm_val_i(cmd_imm_val),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
      .add_a_o(add_a), .add_b_o(add_b), .add_mode_o(add_mode), .add_sub_o(add_sub),
      .add_imm_flag_o(add_imm_flag), .add_imm_reg_o(add_imm_reg),
      .add_result_i(add_result), .busy_o(busy)
`ifdef SIMD_SEQ_ZERO_FLAG_EN
      , .lane_zero_o(lane_zero)
`endif
   );

   // Stand-in for the combinational SIMD adder: independent lanes, wrap modulo 2^w.
   function automatic logic [255:0] adder_model(input logic [255:0] a, input logic [255:0] b,
                                                input logic [2:0] m, input logic s, input logic f,
                                                input logic [7:0] iv);
      int w;
      logic [255:0] mask, la, lb, r, res;
      case (m)
         3'd0: w = 8;
         3'd1: w = 16;
         3'd2: w = 32;
         3'd3: w = 64;
         3'd4: w = 128;
         default: w = 256;
      endcase
      mask = (w == 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
      res = '0;
      for (int l = 0; l < 256 / w; l++) begin
         la  = (a >> (l * w)) & mask;
         lb  = f ? ({{248{iv[7]}}, iv} & mask) : ((b >> (l * w)) & mask);
         r   = (s ? (la - lb) : (la + lb)) & mask;
         res = res | (r << (l * w));
      end
      return res;
   endfunction

   always_comb add_result = adder_model(add_a, add_b, add_mode, add_sub, add_imm_flag, add_imm_reg);

   typedef struct {
      logic [2:0]   mode;
      logic         sub;
      logic         imm;
      logic [7:0]   iv;
      logic [255:0] a;
      logic [255:0] b;
      logic [255:0] exp;
      logic [31:0]  lz;
      logic         stall;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tmo(input string name);
      n_chk++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic send_cmd(input vec_t v);
      int n = 0;
      cmd_mode = v.mode; cmd_sub = v.sub; cmd_imm = v.imm; cmd_imm_val = v.iv;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) tmo("cmd_ready");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("in_ready_after_cmd", 256'(in_ready), 256'(1));
      chk("busy_after_cmd", 256'(busy), 256'(1));
   endtask

   task automatic send_beats(input logic [255:0] d, input logic stall, input int nb);
      int n;
      for (int k = 0; k < nb; k++) begin
         if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_data  = d[k*32 +: 32];
         n = 0;
         while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
         if (n >= 50) tmo("in_ready");
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   // Called right after the last operand handshake: one EXEC cycle, then DRAIN.
   task automatic check_exec_gap();
      chk("exec_in_ready", 256'(in_ready), 256'(0));
      chk("exec_out_valid", 256'(out_valid), 256'(0));
      @(posedge clk); #1;
      chk("first_out_valid", 256'(out_valid), 256'(1));
   endtask

   task automatic recv(input logic [255:0] exp, input logic stall);
      int n;
      logic [31:0] hold;
      logic        hold_last;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
         if (n >= 50) tmo("out_valid");
         if (stall) begin
            repeat ($urandom_range(1, 3)) begin
               hold = out_data; hold_last = out_last;
               @(posedge clk); #1;
               chk("stall_data", 256'(out_data), 256'(hold));
               chk("stall_last", 256'(out_last), 256'(hold_last));
            end
         end
         out_ready = 1'b1;
         chk($sformatf("out_beat%0d", k), 256'(out_data), 256'(exp[k*32 +: 32]));
         chk($sformatf("out_last%0d", k), 256'(out_last), 256'(k == 7));
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic check_held(input vec_t v);
      chk("add_a", add_a, v.a);
      chk("add_b", add_b, v.b);
      chk("add_mode", 256'(add_mode), 256'(v.mode));
      chk("add_sub", 256'(add_sub), 256'(v.sub));
      chk("add_imm_flag", 256'(add_imm_flag), 256'(v.imm));
      chk("add_imm_reg", 256'(add_imm_reg), 256'(v.iv));
`ifdef SIMD_SEQ_ZERO_FLAG_EN
      chk("lane_zero", 256'(lane_zero), 256'(v.lz));
`endif
   endtask

   task automatic load_operands(input vec_t v);
      send_beats(v.a, v.stall, 8);
      if (!v.imm) send_beats(v.b, v.stall, 8);
      check_exec_gap();
   endtask

   task automatic run_vec(input vec_t v);
      send_cmd(v);
      load_operands(v);
      recv(v.exp, v.stall);
      check_held(v);
      chk("idle_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("idle_busy", 256'(busy), 256'(0));
   endtask

   initial begin
      vecs[0] = '{mode: 3'd0, sub: 1'b0, imm: 1'b0, iv: 8'h00, a: {8{32'h01010101}}, b: {8{32'hFFFFFFFF}},
                  exp: 256'd0, lz: 32'hFFFFFFFF, stall: 1'b0};
      vecs[1] = '{mode: 3'd2, sub: 1'b1, imm: 1'b1, iv: 8'h07, a: {8{32'h00000005}}, b: 256'd0,
                  exp: {8{32'hFFFFFFFE}}, lz: 32'h0, stall: 1'b0};
      vecs[2] = '{mode: 3'd7, sub: 1'b0, imm: 1'b0, iv: 8'h00, a: {256{1'b1}}, b: 256'd1,
                  exp: 256'd0, lz: 32'h1, stall: 1'b0};
      vecs[3] = '{mode: 3'd1, sub: 1'b0, imm: 1'b0, iv: 8'h00, a: {8{32'h7FFF8000}}, b: {8{32'h00018000}},
                  exp: {8{32'h80000000}}, lz: 32'h5555, stall: 1'b0};
      vecs[4] = '{mode: 3'd3, sub: 1'b1, imm: 1'b0, iv: 8'h00, a: {4{32'h00000001, 32'h00000000}}, b: {4{64'd1}},
                  exp: {4{32'h00000000, 32'hFFFFFFFF}}, lz: 32'h0, stall: 1'b1};
      vecs[5] = '{mode: 3'd4, sub: 1'b0, imm: 1'b0, iv: 8'h00, a: {256{1'b1}}, b: 256'd1,
                  exp: {{4{32'hFFFFFFFF}}, {4{32'h00000000}}}, lz: 32'h1, stall: 1'b0};
      vecs[6] = '{mode: 3'd0, sub: 1'b0, imm: 1'b1, iv: 8'h80, a: 256'd0, b: 256'd0,
                  exp: {8{32'h80808080}}, lz: 32'h0, stall: 1'b1};
      vecs[7] = '{mode: 3'd5, sub: 1'b1, imm: 1'b0, iv: 8'h00, a: 256'd0, b: 256'd1,
                  exp: {256{1'b1}}, lz: 32'h0, stall: 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_last", 256'(out_last), 256'(0));
      chk("rst_add_a", add_a, 256'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in the middle of loading A: everything returns to idle values at once.
      send_cmd(vecs[4]);
      send_beats(vecs[4].a, 1'b0, 4);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
      chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
      chk("mid_rst_add_a", add_a, 256'd0);
      chk("mid_rst_add_mode", 256'(add_mode), 256'(0));
      chk("mid_rst_add_sub", 256'(add_sub), 256'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_vec(vecs[3]);

      // A command held during DRAIN is only taken once the sequencer is back in IDLE.
      send_cmd(vecs[0]);
      load_operands(vecs[0]);
      cmd_mode = vecs[2].mode; cmd_sub = vecs[2].sub; cmd_imm = vecs[2].imm; cmd_imm_val = vecs[2].iv;
      cmd_valid = 1'b1;
      chk("drain_cmd_ready", 256'(cmd_ready), 256'(0));
      recv(vecs[0].exp, 1'b0);
      chk("post_last_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("post_last_old_mode", 256'(add_mode), 256'(vecs[0].mode));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("accept_busy", 256'(busy), 256'(1));
      chk("accept_in_ready", 256'(in_ready), 256'(1));
      chk("accept_mode", 256'(add_mode), 256'(vecs[2].mode));
      load_operands(vecs[2]);
      recv(vecs[2].exp, 1'b0);
      check_held(vecs[2]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
